bf16_fpu_arbiter: RTL and testbench
===================================

Name: bf16_fpu_arbiter

Overview:
- Shares one multi-cycle bf16 FPU between NUM_REQ requesters; the sigmoid pipeline stages, LUT interpolator and normaliser are typical requesters.
- Each requester issues one operation at a time over a valid/ready handshake and receives a 16-bit result plus an error flag.
- Arbitration is round-robin and non-preemptive: one operation is in flight at a time.
- A watchdog bounds the wait on the FPU.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 64, max cycles in WAIT before aborting with error (>=2).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  synchronous reset, active-low.
- req_valid_i  input  NUM_REQ  per-requester operation valid.
- req_ready_o  output  NUM_REQ  one-hot accept strobe.
- req_op_i  input  NUM_REQ x 3  opcode (fpu_op_t).
- req_op1_i  input  NUM_REQ x 32  operand 1 (32-bit integer for I2F, bf16 in [15:0] otherwise).
- req_op2_i  input  NUM_REQ x 16  operand 2, bf16.
- resp_valid_o  output  NUM_REQ  one-hot response valid.
- resp_ready_i  input  NUM_REQ  per-requester response accept.
- resp_result_o  output  16  result, shared bus; qualified by resp_valid_o.
- resp_error_o  output  1  illegal opcode or timeout; qualified by resp_valid_o.
- fpu_start_o  output  1  issue strobe to FPU.
- fpu_op_o  output  3  opcode to FPU.
- fpu_op1_o  output  32  operand 1.
- fpu_op2_o  output  16  operand 2.
- fpu_ready_i  input  1  FPU can accept.
- fpu_valid_i  input  1  FPU result valid.
- fpu_result_i  input  16  FPU result.
- busy_o  output  1  state != IDLE.

Behaviour:
- Reset (rst_n=0 at a clock edge), including mid-operation:
  - state=IDLE; all outputs 0; result/error registers 0.
  - RR pointer = NUM_REQ-1, so requester 0 has first priority.
  - Any in-flight FPU result is dropped. FPU ready/valid arriving in the first post-reset cycle is ignored.
- IDLE:
  - Grant g = first index with req_valid_i set, searching pointer+1 upward with wrap.
  - req_ready_o[g]=1 combinationally in that cycle; this is the accept.
  - Op, op1 and op2 are latched into registers.
  - Legal opcode -> ISSUE. Opcode 7 -> RESP with error=1, result=0 and no FPU issue.
  - No valid -> stay.
- ISSUE:
  - fpu_start_o=1 with the latched operands, held until fpu_ready_i=1.
  - fpu_ready_i=1 and fpu_valid_i=1 in the same cycle (combinational FPU): capture fpu_result_i, go to RESP.
  - fpu_ready_i=1 alone: go to WAIT with the timeout counter cleared.
- WAIT:
  - fpu_start_o=0; counter increments each cycle.
  - fpu_valid_i=1: capture result, error=0, go to RESP.
  - Counter reaches TIMEOUT_CYCLES-1 without valid: error=1, result=0, go to RESP.
  - fpu_valid_i on the same cycle as timeout: the valid result wins.
  - ISSUE cycles do not count toward the timeout.
- RESP:
  - resp_valid_o[g]=1; result and error stable until resp_ready_i[g]=1.
  - On accept: pointer=g, go to IDLE.
  - New requests are not accepted in the accept cycle; throughput is at most one op per 3 cycles (FPU latency 0).
- Stray fpu_valid_i in IDLE, ISSUE without ready, or RESP is ignored.
- req_valid_i dropping before accept is legal and withdraws the request.
- Operands are never sampled after accept.
- Latency from accept to resp_valid_o = 1 + FPU ready wait + FPU latency + 1 cycles.
- No requester starves: after any grant, every other valid requester is served before g is served again.

Decomposition:
- Extend package bf16_constants with:
  - typedef enum logic [2:0] fpu_op_t: ADD=0, SUB=1, MUL=2, I2F=3, F2I_NEAREST=4, F2I_TRUNC=5, CMP_GE=6, RSVD=7.
  - typedef enum arb_state_t: IDLE, ISSUE, WAIT, RESP.
- One sub-module: rr_arbiter (combinational pointer-based priority pick, NUM_REQ-generic). The FSM and watchdog stay in the top.

Test Plan:
- Requester 0 sends ADD(TWO 0x4000, THREE 0x4040), FPU model latency 3 -> fpu_start_o for one cycle, resp_valid_o=0001 after 5 cycles, result 0x40A0, error 0.
- All four requesters issue MUL(TWO, THREE) simultaneously from reset -> grants in order 0,1,2,3, each result 0x40C0. Requester 0 then re-requests while 1..3 are pending -> served after 3.
- Combinational FPU (ready=valid=1 same cycle), I2F op1=32'd4 -> RESP entered directly from ISSUE, result 0x4080, total accept-to-response 2 cycles.
- FPU never asserts fpu_valid_i, TIMEOUT_CYCLES=64 -> resp_error_o=1, result 0x0000 after 64 WAIT cycles. Next request completes normally.
- Opcode 7 from requester 2 -> fpu_start_o never asserted, resp_valid_o=0100 with error=1. Also: resp_ready_i held low 10 cycles -> response held stable and req_ready_o stays 0.
- rst_n low for one cycle during WAIT -> all outputs 0 next cycle, a late fpu_valid_i is ignored, and requester 0 wins first after reset.

Source files
------------

// File: rtl/bf16_fpu_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// bf16_constants
// Shared definitions for the bf16 datapath blocks: a few bf16 constants, the
// FPU opcode encoding and the state type of the FPU-sharing arbiter.
// ---------------------------------------------------------------------------
package bf16_constants;

    localparam logic [15:0] BF16_ZERO  = 16'h0000;
    localparam logic [15:0] BF16_ONE   = 16'h3F80;
    localparam logic [15:0] BF16_TWO   = 16'h4000;
    localparam logic [15:0] BF16_THREE = 16'h4040;

    typedef enum logic [2:0] {
        ADD         = 3'd0,
        SUB         = 3'd1,
        MUL         = 3'd2,
        I2F         = 3'd3,
        F2I_NEAREST = 3'd4,
        F2I_TRUNC   = 3'd5,
        CMP_GE      = 3'd6,
        RSVD        = 3'd7
    } fpu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

    // Only the reserved encoding is rejected; everything else goes to the FPU.
    function automatic logic isLegalOp(input fpu_op_t op);
        return op != RSVD;
    endfunction

endpackage

// File: rtl/bf16_fpu_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick. Searches the request vector starting one
// past the pointer and wrapping, returning the first set index.
//   i_req   : request vector, one bit per requester
//   i_ptr   : index of the most recently served requester
//   o_valid : at least one request is set
//   o_idx   : index of the winning requester (0 when o_valid is low)
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic               o_valid,
    output logic [IDX_W-1:0]   o_idx
);

    int w_cand;

    // Walk from the farthest candidate to the nearest so the last match, which
    // is the one closest after the pointer, is the one that sticks.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        w_cand  = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_cand = (int'(i_ptr) + k) % NUM_REQ;
            if (i_req[w_cand]) begin
                o_valid = 1'b1;
                o_idx   = IDX_W'(w_cand);
            end
        end
    end

endmodule

// File: rtl/bf16_fpu_arbiter.sv
// ---------------------------------------------------------------------------
// bf16_fpu_arbiter
// Shares one multi-cycle bf16 FPU between NUM_REQ requesters. One operation is
// in flight at a time; grants rotate round-robin and a watchdog aborts an FPU
// wait that runs longer than TIMEOUT_CYCLES.
//   clk, rst_n           : clock, synchronous active-low reset
//   req_valid_i/ready_o  : per-requester issue handshake (ready is one-hot)
//   req_op_i/op1_i/op2_i : per-requester opcode and operands
//   resp_valid_o/ready_i : per-requester response handshake (valid one-hot)
//   resp_result_o/error_o: shared response bus, qualified by resp_valid_o
//   fpu_*                : issue/return interface to the shared FPU
//   busy_o               : an operation is being handled
// ---------------------------------------------------------------------------
module bf16_fpu_arbiter
    import bf16_constants::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic [NUM_REQ-1:0][2:0]  req_op_i,
    input  logic [NUM_REQ-1:0][31:0] req_op1_i,
    input  logic [NUM_REQ-1:0][15:0] req_op2_i,
    output logic [NUM_REQ-1:0]       resp_valid_o,
    input  logic [NUM_REQ-1:0]       resp_ready_i,
    output logic [15:0]              resp_result_o,
    output logic                     resp_error_o,
    output logic                     fpu_start_o,
    output logic [2:0]               fpu_op_o,
    output logic [31:0]              fpu_op1_o,
    output logic [15:0]              fpu_op2_o,
    input  logic                     fpu_ready_i,
    input  logic                     fpu_valid_i,
    input  logic [15:0]              fpu_result_i,
    output logic                     busy_o
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    arb_state_t       r_state;
    arb_state_t       w_nextState;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] r_grant;
    fpu_op_t          r_op;
    logic [31:0]      r_op1;
    logic [15:0]      r_op2;
    logic [15:0]      r_result;
    logic             r_error;
    logic [CNT_W-1:0] r_cnt;

    logic             w_grantValid;
    logic [IDX_W-1:0] w_grantIdx;
    fpu_op_t          w_reqOp;
    logic             w_timeout;
    logic             w_respAccept;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rrArbiter (
        .i_req   (req_valid_i),
        .i_ptr   (r_ptr),
        .o_valid (w_grantValid),
        .o_idx   (w_grantIdx)
    );

    assign w_reqOp      = fpu_op_t'(req_op_i[w_grantIdx]);
    assign w_timeout    = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_respAccept = resp_ready_i[r_grant];

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. A reserved opcode skips the FPU entirely; a valid
    // result arriving on the timeout cycle takes precedence over the abort.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_grantValid) begin
                    w_nextState = isLegalOp(w_reqOp) ? ISSUE : RESP;
                end
            end
            ISSUE: begin
                if (fpu_ready_i) begin
                    w_nextState = fpu_valid_i ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (fpu_valid_i || w_timeout) begin
                    w_nextState = RESP;
                end
            end
            RESP: begin
                if (w_respAccept) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Datapath: operand capture on accept, result/error capture, watchdog
    // counter and round-robin pointer. Operands are only sampled in IDLE, so
    // a requester may change them freely once accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr    <= IDX_W'(NUM_REQ - 1);
            r_grant  <= '0;
            r_op     <= ADD;
            r_op1    <= '0;
            r_op2    <= '0;
            r_result <= '0;
            r_error  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grantValid) begin
                        r_grant  <= w_grantIdx;
                        r_op     <= w_reqOp;
                        r_op1    <= req_op1_i[w_grantIdx];
                        r_op2    <= req_op2_i[w_grantIdx];
                        r_result <= '0;
                        r_error  <= !isLegalOp(w_reqOp);
                    end
                end
                ISSUE: begin
                    if (fpu_ready_i && fpu_valid_i) begin
                        r_result <= fpu_result_i;
                        r_error  <= 1'b0;
                    end else if (fpu_ready_i) begin
                        r_cnt <= '0;
                    end
                end
                WAIT: begin
                    if (fpu_valid_i) begin
                        r_result <= fpu_result_i;
                        r_error  <= 1'b0;
                    end else if (w_timeout) begin
                        r_result <= '0;
                        r_error  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (w_respAccept) begin
                        r_ptr <= r_grant;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output decode. The accept strobe is suppressed while reset is asserted
    // so a requester cannot believe it was accepted by a cycle that resets.
    always_comb begin
        req_ready_o   = '0;
        resp_valid_o  = '0;
        resp_result_o = '0;
        resp_error_o  = 1'b0;
        fpu_start_o   = 1'b0;
        fpu_op_o      = '0;
        fpu_op1_o     = '0;
        fpu_op2_o     = '0;
        busy_o        = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                if (rst_n && w_grantValid) begin
                    req_ready_o[w_grantIdx] = 1'b1;
                end
            end
            ISSUE: begin
                fpu_start_o = 1'b1;
                fpu_op_o    = r_op;
                fpu_op1_o   = r_op1;
                fpu_op2_o   = r_op2;
            end
            RESP: begin
                resp_valid_o[r_grant] = 1'b1;
                resp_result_o         = r_result;
                resp_error_o          = r_error;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bf16_fpu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bf16_fpu_arbiter
// Drives four requesters and a behavioural FPU with programmable latency
// (0 = combinational, -1 = never answers). Expected responses are queued when
// a request is raised and compared when the arbiter hands a response over.
// ---------------------------------------------------------------------------
module tb_bf16_fpu_arbiter;
    import bf16_constants::*;

    logic              clk;
    logic              rst_n;
    logic [3:0]        req_valid_i;
    logic [3:0]        req_ready_o;
    logic [3:0][2:0]   req_op_i;
    logic [3:0][31:0]  req_op1_i;
    logic [3:0][15:0]  req_op2_i;
    logic [3:0]        resp_valid_o;
    logic [3:0]        resp_ready_i;
    logic [15:0]       resp_result_o;
    logic              resp_error_o;
    logic              fpu_start_o;
    logic [2:0]        fpu_op_o;
    logic [31:0]       fpu_op1_o;
    logic [15:0]       fpu_op2_o;
    logic              fpu_ready_i;
    logic              fpu_valid_i;
    logic [15:0]       fpu_result_i;
    logic              busy_o;

    bf16_fpu_arbiter #(
        .NUM_REQ        (4),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_op_i      (req_op_i),
        .req_op1_i     (req_op1_i),
        .req_op2_i     (req_op2_i),
        .resp_valid_o  (resp_valid_o),
        .resp_ready_i  (resp_ready_i),
        .resp_result_o (resp_result_o),
        .resp_error_o  (resp_error_o),
        .fpu_start_o   (fpu_start_o),
        .fpu_op_o      (fpu_op_o),
        .fpu_op1_o     (fpu_op1_o),
        .fpu_op2_o     (fpu_op2_o),
        .fpu_ready_i   (fpu_ready_i),
        .fpu_valid_i   (fpu_valid_i),
        .fpu_result_i  (fpu_result_i),
        .busy_o        (busy_o)
    );

    typedef struct packed {
        logic [1:0]  idx;
        logic [15:0] result;
        logic        err;
    } sbEntry_t;

    sbEntry_t    sbQueue[$];
    int          compareCount;
    int          mismatchCount;
    int          cycleNum;
    int          startCount;
    int          acceptCycle;
    int          respRiseCycle;
    logic [3:0]  prevRespValid;
    int          fpuLatency;
    logic        fpuPending;
    int          fpuCnt;
    logic [15:0] fpuPendResult;

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "[TB] global timeout");
    end

    // Behavioural FPU: known bf16 answers for the exercised cases, and an
    // operand-dependent pattern otherwise so misrouted operands are visible.
    function automatic logic [15:0] fpuCompute(input logic [2:0] op, input logic [31:0] a,
                                               input logic [15:0] b);
        if (op == ADD && a[15:0] == BF16_TWO && b == BF16_THREE) return 16'h40A0;
        if (op == MUL && a[15:0] == BF16_TWO && b == BF16_THREE) return 16'h40C0;
        if (op == I2F && a == 32'd4) return 16'h4080;
        return a[15:0] ^ b ^ {op, 13'b0};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic scoreboardCheck();
        sbEntry_t expEntry;
        logic [1:0] idx;
        idx = 2'd0;
        for (int k = 0; k < 4; k++) if (resp_valid_o[k]) idx = 2'(k);
        checkOutput("resp_onehot", 32'($countones(resp_valid_o)), 32'd1);
        if (sbQueue.size() == 0) begin
            checkOutput("unexpected_resp", 32'(resp_valid_o), 32'd0);
        end else begin
            expEntry = sbQueue.pop_front();
            checkOutput("resp_idx", 32'(idx), 32'(expEntry.idx));
            checkOutput("resp_result", 32'(resp_result_o), 32'(expEntry.result));
            checkOutput("resp_error", 32'(resp_error_o), 32'(expEntry.err));
        end
    endtask

    // One clock cycle: FPU model reacts at the falling edge, outputs are
    // sampled just after it, accepted requests drop just after the rising edge.
    task automatic step();
        logic [3:0] accepted;
        @(negedge clk);
        cycleNum++;
        fpu_valid_i = 1'b0;
        if (fpuPending) begin
            fpuCnt--;
            if (fpuCnt <= 0) begin
                fpu_valid_i  = 1'b1;
                fpu_result_i = fpuPendResult;
                fpuPending   = 1'b0;
            end
        end
        if (fpu_start_o) begin
            startCount++;
            if (fpuLatency == 0) begin
                fpu_valid_i  = 1'b1;
                fpu_result_i = fpuCompute(fpu_op_o, fpu_op1_o, fpu_op2_o);
            end else if (fpuLatency > 0) begin
                fpuPending    = 1'b1;
                fpuCnt        = fpuLatency;
                fpuPendResult = fpuCompute(fpu_op_o, fpu_op1_o, fpu_op2_o);
            end
        end
        #1;
        accepted = req_ready_o;
        if (accepted != 4'd0) acceptCycle = cycleNum;
        if (resp_valid_o != 4'd0 && prevRespValid == 4'd0) respRiseCycle = cycleNum;
        prevRespValid = resp_valid_o;
        if ((resp_valid_o & resp_ready_i) != 4'd0) scoreboardCheck();
        @(posedge clk);
        #1;
        req_valid_i = req_valid_i & ~accepted;
    endtask

    task automatic applyStimulus(input logic [1:0] k, input fpu_op_t op, input logic [31:0] a,
                                 input logic [15:0] b, input logic [15:0] expResult,
                                 input logic expErr);
        sbEntry_t e;
        req_op_i[k]    = op;
        req_op1_i[k]   = a;
        req_op2_i[k]   = b;
        req_valid_i[k] = 1'b1;
        e.idx    = k;
        e.result = expResult;
        e.err    = expErr;
        sbQueue.push_back(e);
    endtask

    task automatic waitDrain(input int budget);
        int n;
        n = 0;
        while (sbQueue.size() != 0 && n < budget) begin
            step();
            n++;
        end
        if (sbQueue.size() != 0) begin
            checkOutput("drain_timeout", 32'(sbQueue.size()), 32'd0);
            sbQueue.delete();
        end
    endtask

    task automatic doReset();
        rst_n       = 1'b0;
        fpuPending  = 1'b0;
        fpu_valid_i = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        compareCount  = 0;
        mismatchCount = 0;
        cycleNum      = 0;
        startCount    = 0;
        acceptCycle   = 0;
        respRiseCycle = 0;
        prevRespValid = '0;
        fpuLatency    = 3;
        fpuPending    = 1'b0;
        fpuCnt        = 0;
        fpuPendResult = '0;
        rst_n         = 1'b0;
        req_valid_i   = '0;
        req_op_i      = '0;
        req_op1_i     = '0;
        req_op2_i     = '0;
        resp_ready_i  = 4'hF;
        fpu_ready_i   = 1'b1;
        fpu_valid_i   = 1'b0;
        fpu_result_i  = '0;

        // Reset state.
        doReset();
        checkOutput("rst_busy", 32'(busy_o), 32'd0);
        checkOutput("rst_req_ready", 32'(req_ready_o), 32'd0);
        checkOutput("rst_resp_valid", 32'(resp_valid_o), 32'd0);
        checkOutput("rst_fpu_start", 32'(fpu_start_o), 32'd0);
        checkOutput("rst_resp_result", 32'(resp_result_o), 32'd0);

        // Single ADD through an FPU with 3 cycles of latency.
        startCount = 0;
        fpuLatency = 3;
        applyStimulus(2'd0, ADD, {16'd0, BF16_TWO}, BF16_THREE, 16'h40A0, 1'b0);
        waitDrain(50);
        checkOutput("add_start_cycles", 32'(startCount), 32'd1);
        checkOutput("add_latency", 32'(respRiseCycle - acceptCycle), 32'd5);

        // Round-robin from reset, then requester 0 re-requests behind 1..3.
        doReset();
        startCount = 0;
        for (int k = 0; k < 4; k++)
            applyStimulus(2'(k), MUL, {16'd0, BF16_TWO}, BF16_THREE, 16'h40C0, 1'b0);
        n = 0;
        while (req_valid_i[0] && n < 20) begin
            step();
            n++;
        end
        applyStimulus(2'd0, SUB, {16'd0, BF16_TWO}, BF16_THREE, 16'h2040, 1'b0);
        waitDrain(200);
        checkOutput("rr_start_cycles", 32'(startCount), 32'd5);

        // Combinational FPU: ISSUE goes straight to RESP.
        fpuLatency = 0;
        applyStimulus(2'd3, I2F, 32'd4, 16'h0000, 16'h4080, 1'b0);
        waitDrain(50);
        checkOutput("i2f_latency", 32'(respRiseCycle - acceptCycle), 32'd2);

        // Watchdog: FPU never answers, then a normal operation follows.
        fpuLatency = -1;
        startCount = 0;
        applyStimulus(2'd1, ADD, {16'd0, BF16_TWO}, BF16_THREE, 16'h0000, 1'b1);
        waitDrain(150);
        checkOutput("timeout_latency", 32'(respRiseCycle - acceptCycle), 32'd66);
        checkOutput("timeout_start_cycles", 32'(startCount), 32'd1);
        fpuLatency = 3;
        applyStimulus(2'd1, MUL, {16'd0, BF16_TWO}, BF16_THREE, 16'h40C0, 1'b0);
        waitDrain(50);

        // Reset while waiting on the FPU; a late result must be dropped and
        // the pointer must be back to favour requester 0.
        fpuLatency     = -1;
        req_op_i[2]    = ADD;
        req_op1_i[2]   = {16'd0, BF16_TWO};
        req_op2_i[2]   = BF16_THREE;
        req_valid_i[2] = 1'b1;
        for (int i = 0; i < 4; i++) step();
        checkOutput("busy_before_reset", 32'(busy_o), 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checkOutput("midrst_busy", 32'(busy_o), 32'd0);
        checkOutput("midrst_resp_valid", 32'(resp_valid_o), 32'd0);
        checkOutput("midrst_fpu_start", 32'(fpu_start_o), 32'd0);
        checkOutput("midrst_resp_error", 32'(resp_error_o), 32'd0);
        fpuPending    = 1'b1;
        fpuCnt        = 1;
        fpuPendResult = 16'h1234;
        step();
        step();
        checkOutput("late_valid_busy", 32'(busy_o), 32'd0);
        checkOutput("late_valid_resp", 32'(resp_valid_o), 32'd0);
        fpuLatency = 3;
        applyStimulus(2'd0, ADD, {16'd0, BF16_TWO}, BF16_THREE, 16'h40A0, 1'b0);
        applyStimulus(2'd1, MUL, {16'd0, BF16_TWO}, BF16_THREE, 16'h40C0, 1'b0);
        applyStimulus(2'd2, I2F, 32'd4, 16'h0000, 16'h4080, 1'b0);
        waitDrain(100);

        // Reserved opcode from requester 2 with its response held back.
        startCount   = 0;
        resp_ready_i = 4'b1011;
        applyStimulus(2'd2, RSVD, {16'd0, BF16_ONE}, BF16_TWO, 16'h0000, 1'b1);
        n = 0;
        while (resp_valid_o == 4'd0 && n < 10) begin
            step();
            n++;
        end
        checkOutput("rsvd_resp_seen", 32'(resp_valid_o), 32'h4);
        applyStimulus(2'd3, ADD, {16'd0, BF16_TWO}, BF16_THREE, 16'h40A0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step();
            checkOutput("hold_resp_valid", 32'(resp_valid_o), 32'h4);
            checkOutput("hold_resp_result", 32'(resp_result_o), 32'h0);
            checkOutput("hold_resp_error", 32'(resp_error_o), 32'd1);
            checkOutput("hold_req_ready", 32'(req_ready_o), 32'd0);
        end
        checkOutput("rsvd_no_start", 32'(startCount), 32'd0);
        resp_ready_i = 4'hF;
        waitDrain(50);
        checkOutput("after_rsvd_start", 32'(startCount), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
